// File: rtl/top_stim_checker.sv
// Stimulus source and response monitor for the `top` increment datapath.
// Sequences DUT reset, drives corner and LFSR vectors, and counts mismatching cycles.
module top_stim_checker #(
  parameter int unsigned NUM_VECTORS  = 64,
  parameter int unsigned RESET_CYCLES = 4,
  parameter logic [69:0] SEED         = 70'h1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        dut_reset_l,
  output logic [1:0]  drv_small,
  output logic [39:0] drv_quad,
  output logic [69:0] drv_wide,
  input  logic [1:0]  mon_small,
  input  logic [39:0] mon_quad,
  input  logic [69:0] mon_wide,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] error_count,
  output logic [15:0] vec_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [69:0] LP_SEED      = (SEED == 70'd0) ? 70'd1 : SEED;
  localparam logic [31:0] LP_HOLD_LAST = 32'(RESET_CYCLES - 1);
  localparam logic [31:0] LP_RUN_LAST  = 32'(NUM_VECTORS - 1);

  function automatic logic [69:0] lfsr_step(input logic [69:0] v);
    return {v[68:0], v[69] ^ v[68] ^ v[54] ^ v[53]};
  endfunction

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_idx;
  logic [69:0] r_lfsr;
  logic [69:0] w_step;
  logic [69:0] w_vec_sel;
  logic        w_hold_last;
  logic        w_run_last;
  logic        w_mismatch;
  logic [15:0] w_err_next;
  logic [1:0]  w_exp_small;
  logic [39:0] w_exp_quad;
  logic [69:0] w_exp_wide;

  assign w_step      = lfsr_step(r_lfsr);
  assign w_hold_last = (r_idx == LP_HOLD_LAST);
  assign w_run_last  = (r_idx == LP_RUN_LAST);
  assign w_exp_small = drv_small + 2'd1;
  assign w_exp_quad  = drv_quad + 40'd1;
  assign w_exp_wide  = drv_wide + 70'd1;
  assign w_err_next  = (w_mismatch && (error_count != 16'hFFFF)) ? error_count + 16'd1 : error_count;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next_state = ST_HOLD;
        else       w_next_state = ST_IDLE;
      end
      ST_HOLD: begin
        if (w_hold_last) w_next_state = ST_RUN;
        else             w_next_state = ST_HOLD;
      end
      ST_RUN: begin
        if (w_run_last) w_next_state = ST_DONE;
        else            w_next_state = ST_RUN;
      end
      ST_DONE: begin
        if (start) w_next_state = ST_HOLD;
        else       w_next_state = ST_DONE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Vector to present on the buses during the next cycle
  always_comb begin
    w_vec_sel = 70'd0;
    case (r_state)
      ST_IDLE, ST_DONE: w_vec_sel = LP_SEED;
      ST_HOLD: begin
        if (w_hold_last) w_vec_sel = {70{1'b1}};
        else             w_vec_sel = w_step;
      end
      ST_RUN: begin
        // Vector 1 is zeros; vector 2 uses the LFSR value left by HOLD.
        if (w_run_last)             w_vec_sel = 70'd0;
        else if (r_idx == 32'd0)    w_vec_sel = 70'd0;
        else if (r_idx == 32'd1)    w_vec_sel = r_lfsr;
        else                        w_vec_sel = w_step;
      end
      default: w_vec_sel = 70'd0;
    endcase
  end

  // Response comparison against the vector currently on the buses
  always_comb begin
    w_mismatch = 1'b0;
    case (r_state)
      ST_HOLD: w_mismatch = (mon_small != 2'd0) || (mon_quad != 40'd0) || (mon_wide != 70'd0);
      ST_RUN:  w_mismatch = (mon_small != w_exp_small) || (mon_quad != w_exp_quad) ||
                            (mon_wide != w_exp_wide);
      default: w_mismatch = 1'b0;
    endcase
  end

  // Drive, LFSR and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx       <= 32'd0;
      r_lfsr      <= LP_SEED;
      dut_reset_l <= 1'b0;
      drv_small   <= 2'd0;
      drv_quad    <= 40'd0;
      drv_wide    <= 70'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      error_count <= 16'd0;
      vec_count   <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_idx       <= 32'd0;
            r_lfsr      <= LP_SEED;
            dut_reset_l <= 1'b0;
            drv_wide    <= w_vec_sel;
            drv_quad    <= w_vec_sel[69:30];
            drv_small   <= w_vec_sel[1:0];
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            error_count <= 16'd0;
            vec_count   <= 16'd0;
          end
        end
        ST_HOLD: begin
          r_lfsr      <= w_step;
          error_count <= w_err_next;
          drv_wide    <= w_vec_sel;
          drv_quad    <= w_vec_sel[69:30];
          drv_small   <= w_vec_sel[1:0];
          if (w_hold_last) begin
            r_idx       <= 32'd0;
            dut_reset_l <= 1'b1;
          end else begin
            r_idx <= r_idx + 32'd1;
          end
        end
        ST_RUN: begin
          error_count <= w_err_next;
          vec_count   <= vec_count + 16'd1;
          drv_wide    <= w_vec_sel;
          drv_quad    <= w_vec_sel[69:30];
          drv_small   <= w_vec_sel[1:0];
          if (r_idx >= 32'd2) r_lfsr <= w_step;
          if (w_run_last) begin
            dut_reset_l <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            pass        <= (w_err_next == 16'd0);
          end else begin
            r_idx <= r_idx + 32'd1;
          end
        end
        default: r_idx <= 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_top_stim_checker.sv
// Closed-loop bench: a behavioural `top` with optional fault injection feeds the checker,
// and the drive sequence is predicted from the LFSR/corner-vector rules.
module tb_top_stim_checker;

  localparam int N = 64;
  localparam int R = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, b_start;
  logic        dut_reset_l, busy, done, pass;
  logic [1:0]  drv_small, mon_small;
  logic [39:0] drv_quad, mon_quad;
  logic [69:0] drv_wide, mon_wide;
  logic [15:0] error_count, vec_count;

  logic        b_dut_reset_l, b_busy, b_done, b_pass;
  logic [1:0]  b_drv_small, b_mon_small;
  logic [39:0] b_drv_quad, b_mon_quad;
  logic [69:0] b_drv_wide, b_mon_wide;
  logic [15:0] b_error_count, b_vec_count;

  int          fault_mode;
  logic [1:0]  fm_small;
  logic [39:0] fm_quad;
  logic [69:0] fm_wide;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [69:0] exp_vec[$];

  // Behavioural top with fault injection
  always_comb begin
    mon_small = dut_reset_l ? drv_small + 2'd1 : 2'd0;
    mon_quad  = dut_reset_l ? drv_quad + 40'd1 : 40'd0;
    mon_wide  = dut_reset_l ? drv_wide + 70'd1 : 70'd0;
    if (fault_mode == 1 && dut_reset_l) mon_quad[0] = ~mon_quad[0];
    if (fault_mode == 2 && !dut_reset_l) mon_small = 2'b01;
    mon_small = mon_small ^ fm_small;
    mon_quad  = mon_quad ^ fm_quad;
    mon_wide  = mon_wide ^ fm_wide;
  end

  always_comb begin
    b_mon_small = b_dut_reset_l ? b_drv_small + 2'd1 : 2'd0;
    b_mon_quad  = b_dut_reset_l ? b_drv_quad + 40'd1 : 40'd0;
    b_mon_wide  = b_dut_reset_l ? b_drv_wide + 70'd1 : 70'd0;
  end

  top_stim_checker #(.NUM_VECTORS(N), .RESET_CYCLES(R), .SEED(70'h1)) dut (
    .clk(clk), .reset(reset), .start(start), .dut_reset_l(dut_reset_l),
    .drv_small(drv_small), .drv_quad(drv_quad), .drv_wide(drv_wide),
    .mon_small(mon_small), .mon_quad(mon_quad), .mon_wide(mon_wide),
    .busy(busy), .done(done), .pass(pass), .error_count(error_count), .vec_count(vec_count)
  );

  top_stim_checker #(.NUM_VECTORS(2), .RESET_CYCLES(1), .SEED(70'h0)) dut2 (
    .clk(clk), .reset(reset), .start(b_start), .dut_reset_l(b_dut_reset_l),
    .drv_small(b_drv_small), .drv_quad(b_drv_quad), .drv_wide(b_drv_wide),
    .mon_small(b_mon_small), .mon_quad(b_mon_quad), .mon_wide(b_mon_wide),
    .busy(b_busy), .done(b_done), .pass(b_pass), .error_count(b_error_count),
    .vec_count(b_vec_count)
  );

  function automatic logic [69:0] ref_step(input logic [69:0] v);
    logic [69:0] taps;
    taps = 70'd0;
    taps[69] = 1'b1;
    taps[68] = 1'b1;
    taps[54] = 1'b1;
    taps[53] = 1'b1;
    return {v[68:0], ^(v & taps)};
  endfunction

  task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected bus contents for every HOLD and RUN cycle, in order
  task automatic build_expected(input logic [69:0] seed, input int r, input int n);
    logic [69:0] v;
    exp_vec.delete();
    v = (seed == 70'd0) ? 70'd1 : seed;
    for (int h = 0; h < r; h++) begin
      exp_vec.push_back(v);
      v = ref_step(v);
    end
    exp_vec.push_back({70{1'b1}});
    exp_vec.push_back(70'd0);
    for (int k = 2; k < n; k++) begin
      exp_vec.push_back(v);
      v = ref_step(v);
    end
  endtask

  task automatic check_drive(input string tag, input logic [1:0] s, input logic [39:0] q,
                             input logic [69:0] w, input logic [69:0] v);
    logic [69:0] t;
    t = v;
    check({tag, "_wide"}, w, t);
    check({tag, "_quad"}, 70'(q), 70'(t[69:30]));
    check({tag, "_small"}, 70'(s), 70'(t[1:0]));
  endtask

  task automatic clear_faults();
    fm_small = 2'd0;
    fm_quad  = 40'd0;
    fm_wide  = 70'd0;
  endtask

  task automatic run_seq(input int mode, input int ign_at, input int abort_at, input bit rand_faults);
    int exp_err;
    exp_err = 0;
    build_expected(70'h1, R, N);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    fault_mode = mode;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < R + N; c++) begin
      @(negedge clk);
      start = (c == ign_at);
      check("busy", 70'(busy), 70'd1);
      check("done_low", 70'(done), 70'd0);
      check("dut_reset_l", 70'(dut_reset_l), 70'(c >= R));
      check_drive("drv", drv_small, drv_quad, drv_wide, exp_vec[c]);
      if (c == 0) begin
        check("err_cleared", 70'(error_count), 70'd0);
        check("vec_cleared", 70'(vec_count), 70'd0);
      end
      if (c == R && mode == 0 && !rand_faults) begin
        check("wrap_small", 70'(mon_small), 70'd0);
        check("wrap_quad", 70'(mon_quad), 70'd0);
        check("wrap_wide", mon_wide, 70'd0);
      end
      if (c == R + 1 && mode == 0 && !rand_faults) check("zero_vec_wide", mon_wide, 70'd1);
      if (c == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        fault_mode = 0;
        clear_faults();
        check("abort_busy", 70'(busy), 70'd0);
        check("abort_done", 70'(done), 70'd0);
        check("abort_err", 70'(error_count), 70'd0);
        check("abort_vec", 70'(vec_count), 70'd0);
        check("abort_rst_l", 70'(dut_reset_l), 70'd0);
        check_drive("abort_drv", drv_small, drv_quad, drv_wide, 70'd0);
        return;
      end
      clear_faults();
      if (rand_faults) begin
        if ($urandom_range(0, 3) == 0) fm_small = 2'($urandom_range(1, 3));
        if ($urandom_range(0, 3) == 0) fm_quad = 40'd1 << $urandom_range(0, 39);
        if ($urandom_range(0, 3) == 0) fm_wide = 70'd1 << $urandom_range(0, 69);
        if (fm_small != 2'd0 || fm_quad != 40'd0 || fm_wide != 70'd0) exp_err++;
      end
      if (mode == 1 && c >= R) exp_err++;
      if (mode == 2 && c < R) exp_err++;
    end
    @(negedge clk);
    start = 1'b0;
    fault_mode = 0;
    clear_faults();
    check("done", 70'(done), 70'd1);
    check("busy_low", 70'(busy), 70'd0);
    check("done_rst_l", 70'(dut_reset_l), 70'd0);
    check_drive("done_drv", drv_small, drv_quad, drv_wide, 70'd0);
    check("error_count", 70'(error_count), 70'(exp_err));
    check("vec_count", 70'(vec_count), 70'(N));
    check("pass", 70'(pass), 70'(exp_err == 0));
    @(negedge clk);
    check("done_hold", 70'(done), 70'd1);
    check("err_hold", 70'(error_count), 70'(exp_err));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    b_start = 1'b0;
    fault_mode = 0;
    clear_faults();
    repeat (3) @(negedge clk);
    check("rst_busy", 70'(busy), 70'd0);
    check("rst_done", 70'(done), 70'd0);
    check("rst_pass", 70'(pass), 70'd0);
    check("rst_err", 70'(error_count), 70'd0);
    check("rst_vec", 70'(vec_count), 70'd0);
    check("rst_rst_l", 70'(dut_reset_l), 70'd0);
    check_drive("rst_drv", drv_small, drv_quad, drv_wide, 70'd0);
    reset = 1'b0;

    run_seq(0, -1, -1, 1'b0);
    run_seq(1, -1, -1, 1'b0);
    run_seq(0, -1, -1, 1'b0);
    run_seq(2, -1, -1, 1'b0);
    run_seq(0, R + $urandom_range(2, N - 3), -1, 1'b0);
    run_seq(0, -1, R + 10, 1'b0);
    run_seq(0, -1, -1, 1'b0);
    for (int i = 0; i < 3; i++) run_seq(0, -1, -1, 1'b1);

    build_expected(70'h0, 1, 2);
    @(negedge clk);
    b_start = 1'b1;
    @(posedge clk);
    #1 b_start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("nv2_busy", 70'(b_busy), 70'd1);
      check("nv2_rst_l", 70'(b_dut_reset_l), 70'(c >= 1));
      check_drive("nv2_drv", b_drv_small, b_drv_quad, b_drv_wide, exp_vec[c]);
    end
    @(negedge clk);
    check("nv2_done", 70'(b_done), 70'd1);
    check("nv2_busy_low", 70'(b_busy), 70'd0);
    check("nv2_vec", 70'(b_vec_count), 70'd2);
    check("nv2_err", 70'(b_error_count), 70'd0);
    check("nv2_pass", 70'(b_pass), 70'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
